function_unit_seq: RTL and testbench

- Execute/write-back stage directly downstream of the 8x16 register file read ports.
- Consumes the A/B operands and a destination address, then performs the selected micro-operation.
- Single-cycle ops finish in one cycle; 16x16 multiply is multi-cycle shift-add.
- Returns the result to the register file write port (DData/DAddress/ReadOrWrite) as a one-cycle write strobe, and updates Z/N/C/V status flags.

---
 rtl/function_unit_seq.sv | 152 +++++++++++++++
 tb/tb_function_unit_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/function_unit_seq.sv
// Execute/write-back stage behind the register file read ports.
// Single-cycle ALU ops complete in one cycle; MUL runs a WIDTH-step shift-add.
module function_unit_seq #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] AData,
  input  logic [WIDTH-1:0] BData,
  input  logic [AW-1:0]    dest,
  output logic [WIDTH-1:0] DData,
  output logic [AW-1:0]    DAddress,
  output logic             ReadOrWrite,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       flags
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_nxt;
  logic [AW-1:0]    dest_r;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             c, v, legal;

  assign busy = (state != IDLE);
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // Single-cycle result is computed straight from the request so it lands in WB.
  always_comb begin
    sum   = '0;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    legal = 1'b1;
    case (op)
      4'd0: res = AData;
      4'd1: begin
        sum = {1'b0, AData} + ONE;
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = ~AData[WIDTH-1] & res[WIDTH-1];
      end
      4'd2: begin
        sum = {1'b0, AData} + {1'b0, BData};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (AData[WIDTH-1] == BData[WIDTH-1]) && (res[WIDTH-1] != AData[WIDTH-1]);
      end
      4'd3: begin
        // top bit of the widened difference is the unsigned borrow
        sum = {1'b0, AData} - {1'b0, BData};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (AData[WIDTH-1] != BData[WIDTH-1]) && (res[WIDTH-1] != AData[WIDTH-1]);
      end
      4'd4: begin
        sum = {1'b0, AData} - ONE;
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = AData[WIDTH-1] & ~res[WIDTH-1];
      end
      4'd5: res = AData & BData;
      4'd6: res = AData | BData;
      4'd7: res = AData ^ BData;
      4'd8: res = ~AData;
      4'd9: begin
        res = {BData[WIDTH-2:0], 1'b0};
        c   = BData[WIDTH-1];
      end
      4'd10: begin
        res = {1'b0, BData[WIDTH-1:1]};
        c   = BData[0];
      end
      4'd11: res = '0;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      dest_r      <= '0;
      DData       <= '0;
      DAddress    <= '0;
      ReadOrWrite <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      flags       <= 4'b0;
    end else begin
      ReadOrWrite <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (op == OP_MUL) begin
            state  <= MUL;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= AData;
            mplier <= BData;
            dest_r <= dest;
          end else begin
            state <= WB;
            done  <= 1'b1;
            if (legal) begin
              ReadOrWrite <= 1'b1;
              DData       <= res;
              DAddress    <= dest;
              flags       <= {res == '0, res[WIDTH-1], c, v};
            end else begin
              err <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= WB;
            ReadOrWrite <= 1'b1;
            done        <= 1'b1;
            DData       <= acc_nxt;
            DAddress    <= dest_r;
            flags       <= {acc_nxt == '0, acc_nxt[WIDTH-1], 2'b00};
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_function_unit_seq.sv
// Directed bench for function_unit_seq: ALU ops, flag corners, MUL latency, illegal op, abort.
module tb_function_unit_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0]  op = '0;
  logic [15:0] AData = '0, BData = '0;
  logic [2:0]  dest = '0;
  logic [15:0] DData;
  logic [2:0]  DAddress;
  logic        ReadOrWrite, busy, done, err;
  logic [3:0]  flags;
  int checks = 0, fails = 0;

  function_unit_seq #(.WIDTH(16), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .AData(AData), .BData(BData),
    .dest(dest), .DData(DData), .DAddress(DAddress), .ReadOrWrite(ReadOrWrite),
    .busy(busy), .done(done), .err(err), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d);
    start = 1'b1; op = o; AData = a; BData = b; dest = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wb_chk(input string tag, input logic [15:0] d, input logic [2:0] a,
                        input logic [3:0] f);
    chk({tag, "_row"}, ReadOrWrite, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_data"}, DData, d);
    chk({tag, "_addr"}, DAddress, a);
    chk({tag, "_flags"}, flags, f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // reset with a start held high: must be ignored
    start = 1'b1; op = 4'd2; AData = 16'h1234; BData = 16'h1; dest = 3'd4;
    repeat (2) @(negedge clk);
    chk("rst_data", DData, 0);
    chk("rst_addr", DAddress, 0);
    chk("rst_row", ReadOrWrite, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_flags", flags, 0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);

    issue(4'd2, 16'h7FFF, 16'h0001, 3'd5);
    wb_chk("add", 16'h8000, 3'd5, 4'b0101);
    chk("add_busy", busy, 1);
    @(negedge clk);
    chk("add_row_off", ReadOrWrite, 0);
    chk("add_busy_off", busy, 0);
    chk("add_hold", DData, 16'h8000);

    issue(4'd3, 16'h0003, 16'h0003, 3'd1);
    wb_chk("sub", 16'h0000, 3'd1, 4'b1000);
    @(negedge clk);
    issue(4'd4, 16'h0000, 16'h0000, 3'd2);
    wb_chk("dec", 16'hFFFF, 3'd2, 4'b0110);
    @(negedge clk);
    issue(4'd9, 16'h0000, 16'h8001, 3'd3);
    wb_chk("shl", 16'h0002, 3'd3, 4'b0010);
    @(negedge clk);
    issue(4'd10, 16'h0000, 16'h8001, 3'd4);
    wb_chk("shr", 16'h4000, 3'd4, 4'b0010);
    @(negedge clk);

    issue(4'd13, 16'h1111, 16'h2222, 3'd6);
    chk("ill_done", done, 1);
    chk("ill_err", err, 1);
    chk("ill_row", ReadOrWrite, 0);
    chk("ill_flags", flags, 4'b0010);
    chk("ill_data", DData, 16'h4000);
    @(negedge clk);
    chk("ill_err_off", err, 0);

    // MUL with a stray start during the multiply
    issue(4'd11, 16'h0123, 16'h0045, 3'd7);
    chk("mul_busy0", busy, 1);
    chk("mul_row0", ReadOrWrite, 0);
    n = 0;
    while (!ReadOrWrite && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 3) begin start = 1'b1; op = 4'd0; AData = 16'hDEAD; dest = 3'd2; end
      if (n == 5) start = 1'b0;
      if (n == 8) chk("mul_busy_mid", busy, 1);
    end
    chk("mul_lat", n, 16);
    wb_chk("mul", 16'h4E6F, 3'd7, 4'b0000);
    chk("mul_busy_wb", busy, 1);
    @(negedge clk);
    chk("mul_idle", busy, 0);
    chk("mul_row_off", ReadOrWrite, 0);

    issue(4'd11, 16'hFFFF, 16'hFFFF, 3'd1);
    n = 0;
    while (!ReadOrWrite && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mul2_lat", n, 16);
    wb_chk("mul2", 16'h0001, 3'd1, 4'b0000);
    @(negedge clk);

    // abort in MUL cycle 8, then restart right away
    issue(4'd11, 16'h0003, 16'h0005, 3'd6);
    repeat (7) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_row", ReadOrWrite, 0);
    chk("abort_done", done, 0);
    chk("abort_data", DData, 0);
    rst_n = 1'b1;
    issue(4'd2, 16'h0001, 16'h0002, 3'd3);
    wb_chk("restart", 16'h0003, 3'd3, 4'b0000);
    repeat (20) @(negedge clk);
    chk("abort_no_late_write", DData, 16'h0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
